// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel switch debouncer.
package debounce_pkg;

    localparam int DEFAULT_STABLE_COUNT = 10;
    localparam int DEFAULT_PRESCALE     = 1;

    // Bits needed to hold 0..value-1, never fewer than one.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        while ((width < 31) && (int'(32'd1 << width) < value)) begin
            width++;
        end
        if (width < 1) begin
            return 1;
        end else begin
            return width;
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: two-flop synchroniser, stability counter, level register
// and registered rise/fall strobes.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter logic RESET_VALUE  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw_in,
    output logic sw_out,
    output logic rise,
    output logic fall,
    output logic toggle
);

    localparam int                 CNT_W    = clog2_min1(STABLE_COUNT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic             s1_r;
    logic             s2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             rise_r;
    logic             fall_r;

    logic             mismatch_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_nxt_s;
    logic             rise_nxt_s;
    logic             fall_nxt_s;

    assign mismatch_s = (s2_r != level_r);

    // Qualification: any cycle back at the current level restarts the count.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        if (!mismatch_s) begin
            cnt_nxt_s = '0;
        end else if (tick) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s   = '0;
                level_nxt_s = s2_r;
                rise_nxt_s  = s2_r;
                fall_nxt_s  = ~s2_r;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Synchroniser, counter, level and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= RESET_VALUE;
            s2_r    <= RESET_VALUE;
            cnt_r   <= '0;
            level_r <= RESET_VALUE;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            s1_r    <= sw_in;
            s2_r    <= s1_r;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
        end
    end

    assign sw_out = level_r;
    assign rise   = rise_r;
    assign fall   = fall_r;
    // Next-cycle strobe, so the top can register changed in step with rise/fall.
    assign toggle = rise_nxt_s | fall_nxt_s;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample-tick prescaler feeding N_CH
// independent channels, plus a registered OR of all strobes.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   N_CH         = 16,
    parameter int   PRESCALE     = DEFAULT_PRESCALE,
    parameter int   STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter logic RESET_VALUE  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            changed
);

    logic            tick_s;
    logic [N_CH-1:0] toggle_s;
    logic            changed_r;

    if (PRESCALE == 1) begin : g_no_pre
        assign tick_s = 1'b1;
    end else begin : g_pre
        localparam int               PRE_W    = clog2_min1(PRESCALE);
        localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

        logic [PRE_W-1:0] pre_r;

        assign tick_s = (pre_r == PRE_LAST);

        // Free-running prescaler; restarts from zero on reset so the first
        // tick lands PRESCALE cycles after release.
        always_ff @(posedge clk) begin
            if (rst) begin
                pre_r <= '0;
            end else if (tick_s) begin
                pre_r <= '0;
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_COUNT (STABLE_COUNT),
            .RESET_VALUE  (RESET_VALUE)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick_s),
            .sw_in  (sw_in[i]),
            .sw_out (sw_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .toggle (toggle_s[i])
        );
    end

    // Aggregate strobe, registered so it lines up with the per-channel strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_r <= 1'b0;
        end else begin
            changed_r <= |toggle_s;
        end
    end

    assign changed = changed_r;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench: two debouncer instances against a cycle-level model of
// the qualification rules, plus hand-computed latency/count expectations.
module tb_debounce_multi;

    localparam int MN  [2] = '{4, 2};
    localparam int MP  [2] = '{1, 4};
    localparam int MSC [2] = '{10, 3};

    logic       clk;
    logic       rst_a, rst_b;
    logic [3:0] sw_a, out_a, rise_a, fall_a;
    logic [1:0] sw_b, out_b, rise_b, fall_b;
    logic       chg_a, chg_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // model state: [instance][channel]
    bit m_s1  [2][4];
    bit m_s2  [2][4];
    bit m_out [2][4];
    bit m_rise[2][4];
    bit m_fall[2][4];
    int m_run [2][4];
    bit m_chg [2];
    int m_k   [2];

    // observed strobe history
    int rise_cnt_a[4], fall_cnt_a[4], rise_cyc_a[4], fall_cyc_a[4];
    int rise_cnt_b[2], rise_cyc_b[2];
    int chg_cnt_a;

    int c0, c_r, c_last, chg0, prior;

    debounce_multi #(.N_CH(4), .PRESCALE(1), .STABLE_COUNT(10), .RESET_VALUE(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .sw_in(sw_a), .sw_out(out_a),
        .rise(rise_a), .fall(fall_a), .changed(chg_a));

    debounce_multi #(.N_CH(2), .PRESCALE(4), .STABLE_COUNT(3), .RESET_VALUE(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .sw_in(sw_b), .sw_out(out_b),
        .rise(rise_b), .fall(fall_b), .changed(chg_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Advance the model by the posedge that just happened. Inputs change only
    // just after negedges, so the values seen here are the ones sampled.
    task automatic model_step();
        bit rb, tk, sw;
        for (int u = 0; u < 2; u++) begin
            rb = (u == 0) ? rst_a : rst_b;
            m_chg[u] = 1'b0;
            if (rb) begin
                m_k[u] = 0;
                for (int c = 0; c < 4; c++) begin
                    m_s1[u][c] = 1'b0; m_s2[u][c] = 1'b0; m_out[u][c] = 1'b0;
                    m_rise[u][c] = 1'b0; m_fall[u][c] = 1'b0; m_run[u][c] = 0;
                end
            end else begin
                tk = ((m_k[u] % MP[u]) == MP[u] - 1);
                for (int c = 0; c < MN[u]; c++) begin
                    sw = (u == 0) ? sw_a[c] : sw_b[c];
                    m_rise[u][c] = 1'b0;
                    m_fall[u][c] = 1'b0;
                    if (m_s2[u][c] != m_out[u][c]) begin
                        if (tk) m_run[u][c]++;
                        if (m_run[u][c] == MSC[u]) begin
                            m_out[u][c]  = m_s2[u][c];
                            m_run[u][c]  = 0;
                            m_rise[u][c] = m_out[u][c];
                            m_fall[u][c] = ~m_out[u][c];
                            m_chg[u]     = 1'b1;
                        end
                    end else begin
                        m_run[u][c] = 0;
                    end
                    m_s2[u][c] = m_s1[u][c];
                    m_s1[u][c] = sw;
                end
                m_k[u]++;
            end
        end
    endtask

    // Per-cycle model comparison and strobe logging.
    initial begin
        logic [3:0] eo, er, ef;
        logic [1:0] bo, br, bf;
        forever begin
            @(negedge clk);
            cyc++;
            model_step();
            for (int c = 0; c < 4; c++) begin
                eo[c] = m_out[0][c]; er[c] = m_rise[0][c]; ef[c] = m_fall[0][c];
            end
            for (int c = 0; c < 2; c++) begin
                bo[c] = m_out[1][c]; br[c] = m_rise[1][c]; bf[c] = m_fall[1][c];
            end
            chk("a_sw_out", int'(out_a), int'(eo));
            chk("a_rise", int'(rise_a), int'(er));
            chk("a_fall", int'(fall_a), int'(ef));
            chk("a_changed", int'(chg_a), int'(m_chg[0]));
            chk("b_sw_out", int'(out_b), int'(bo));
            chk("b_rise", int'(rise_b), int'(br));
            chk("b_fall", int'(fall_b), int'(bf));
            chk("b_changed", int'(chg_b), int'(m_chg[1]));
            for (int c = 0; c < 4; c++) begin
                if (rise_a[c]) begin rise_cnt_a[c]++; rise_cyc_a[c] = cyc; end
                if (fall_a[c]) begin fall_cnt_a[c]++; fall_cyc_a[c] = cyc; end
            end
            for (int c = 0; c < 2; c++) begin
                if (rise_b[c]) begin rise_cnt_b[c]++; rise_cyc_b[c] = cyc; end
            end
            if (chg_a) chg_cnt_a++;
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        sw_a  = 4'hF; sw_b  = 2'b00;
        step(3);
        chk("reset_sw_out", int'(out_a), 0);
        chk("reset_strobes", int'({rise_a, fall_a}), 0);
        chk("reset_changed", int'(chg_a), 0);

        rst_a = 1'b0; sw_a = 4'h0;
        step(20);
        chk("idle_strobes", rise_cnt_a[0] + rise_cnt_a[1] + rise_cnt_a[2] + rise_cnt_a[3]
                            + fall_cnt_a[0] + fall_cnt_a[1] + fall_cnt_a[2] + fall_cnt_a[3], 0);

        // clean step on ch0: first sampled at E = c0+1, toggles after E+11
        c0 = cyc; sw_a[0] = 1'b1;
        step(15);
        chk("step_latency", rise_cyc_a[0] - (c0 + 1), 11);
        chk("step_rise_cnt", rise_cnt_a[0], 1);
        chk("step_others", int'(out_a[3:1]), 0);

        // 9-cycle pulse on ch1 is rejected
        sw_a[1] = 1'b1; step(9); sw_a[1] = 1'b0; step(25);
        chk("pulse9_rise_cnt", rise_cnt_a[1], 0);
        chk("pulse9_level", int'(out_a[1]), 0);

        // 10-cycle pulse is accepted, then falls 11 edges after it ends
        c0 = cyc; sw_a[1] = 1'b1; step(10); sw_a[1] = 1'b0; step(25);
        chk("pulse10_rise_at", rise_cyc_a[1] - (c0 + 1), 11);
        chk("pulse10_fall_at", fall_cyc_a[1] - (c0 + 1), 21);
        chk("pulse10_rise_cnt", rise_cnt_a[1], 1);
        chk("pulse10_fall_cnt", fall_cnt_a[1], 1);

        // bounce on ch2: 13 toggles every 3 cycles, ending high
        for (int i = 0; i < 13; i++) begin
            sw_a[2] = ~sw_a[2];
            c_last = cyc;
            step(3);
        end
        step(20);
        chk("bounce_rise_cnt", rise_cnt_a[2], 1);
        chk("bounce_fall_cnt", fall_cnt_a[2], 0);
        chk("bounce_latency", rise_cyc_a[2] - (c_last + 1), 11);

        // simultaneous fall on ch0 and rise on ch3
        chg0 = chg_cnt_a; c0 = cyc;
        sw_a[0] = 1'b0; sw_a[3] = 1'b1;
        step(15);
        chk("simul_same_cycle", fall_cyc_a[0], rise_cyc_a[3]);
        chk("simul_latency", fall_cyc_a[0] - (c0 + 1), 11);
        chk("simul_changed_pulses", chg_cnt_a - chg0, 1);

        // reset while ch1 is at count 5 discards the progress
        prior = rise_cnt_a[1];
        sw_a[1] = 1'b1;
        step(7);
        rst_a = 1'b1; step(2); rst_a = 1'b0;
        c_r = cyc; chg0 = chg_cnt_a;
        step(20);
        chk("abort_rise_cnt", rise_cnt_a[1] - prior, 1);
        chk("abort_restart", rise_cyc_a[1] - (c_r + 1), 11);
        chk("abort_changed_pulses", chg_cnt_a - chg0, 1);

        // prescaled instance: ticks land at edges c_r+4k after release
        rst_b = 1'b0; c_r = cyc;
        step(4);  sw_b[0] = 1'b1;
        step(16); sw_b[1] = 1'b1;
        step(4);  sw_b[1] = 1'b0;
        step(1);  sw_b[1] = 1'b1;
        step(20);
        chk("pre_rise_at", rise_cyc_b[0] - c_r, 16);
        chk("pre_glitch_rise_at", rise_cyc_b[1] - c_r, 36);
        chk("pre_rise_cnt0", rise_cnt_b[0], 1);
        chk("pre_rise_cnt1", rise_cnt_b[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
